// File: rtl/effects_output_buffer.sv
// Elastic FIFO between the effects chain and the AC97 slot serializer.
// Primes to a fill threshold, then pops one sample per slot request.
module effects_output_buffer #(
  parameter int WIDTH     = 12,
  parameter int OUT_WIDTH = 20,
  parameter int LOG_DEPTH = 4,
  parameter int PREFILL   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_ready,
  input  logic [WIDTH-1:0]     sample_in,
  input  logic                 ac97_ready,
  input  logic                 clear_flags,
  output logic [OUT_WIDTH-1:0] to_ac97_data,
  output logic [LOG_DEPTH:0]   level,
  output logic                 running,
  output logic                 underrun,
  output logic                 overflow
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] DEPTH_L   = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0] PREFILL_L = (LOG_DEPTH+1)'(PREFILL);

  // Handshake: sample_ready and ac97_ready are single-cycle strobes with no
  // back-pressure; a strobe that cannot be served is counted as overflow
  // (write side) or underrun (read side, only while running).
  typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;

  state_t                 state;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic [LOG_DEPTH-1:0]   wr_ptr;
  logic [LOG_DEPTH-1:0]   rd_ptr;
  logic                   full;
  logic                   do_pop;
  logic                   do_write;
  logic                   drop;
  logic                   starve;

  assign full     = (level == DEPTH_L);
  assign do_pop   = (state == RUN) && ac97_ready && (level != '0);
  // A pop in the same cycle frees the slot the incoming sample needs.
  assign do_write = sample_ready && (!full || do_pop);
  assign drop     = sample_ready && full && !do_pop;
  assign starve   = (state == RUN) && ac97_ready && (level == '0);

  always_ff @(posedge clock) begin
    if (!reset && do_write) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= PRIME;
      running      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      to_ac97_data <= '0;
      underrun     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        to_ac97_data <= OUT_WIDTH'(mem[rd_ptr]) << (OUT_WIDTH - WIDTH);
      end
      level <= level + (LOG_DEPTH+1)'(do_write) - (LOG_DEPTH+1)'(do_pop);

      case (state)
        PRIME: if (level >= PREFILL_L) begin
          state   <= RUN;
          running <= 1'b1;
        end
        RUN: if (starve) begin
          state   <= PRIME;
          running <= 1'b0;
        end
        default: begin
          state   <= PRIME;
          running <= 1'b0;
        end
      endcase

      // Set events take priority over a simultaneous clear.
      if (drop)             overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
      if (starve)           underrun <= 1'b1;
      else if (clear_flags) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_effects_output_buffer.sv
// Directed bench for effects_output_buffer: priming, ordering, overflow,
// full-plus-pop, underrun, flag priority and pointer wrap.
module tb_effects_output_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        sample_ready;
  logic [11:0] sample_in;
  logic        ac97_ready;
  logic        clear_flags;
  logic [19:0] to_ac97_data;
  logic [4:0]  level;
  logic        running;
  logic        underrun;
  logic        overflow;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  effects_output_buffer dut (
    .clock        (clock),
    .reset        (reset),
    .sample_ready (sample_ready),
    .sample_in    (sample_in),
    .ac97_ready   (ac97_ready),
    .clear_flags  (clear_flags),
    .to_ac97_data (to_ac97_data),
    .level        (level),
    .running      (running),
    .underrun     (underrun),
    .overflow     (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input logic sr, input logic [11:0] d, input logic ar, input logic cf);
    sample_ready = sr;
    sample_in    = d;
    ac97_ready   = ar;
    clear_flags  = cf;
    @(posedge clock);
    #1;
    sample_ready = 1'b0;
    ac97_ready   = 1'b0;
    clear_flags  = 1'b0;
  endtask

  function automatic logic [19:0] slot(input logic [11:0] v);
    return {v, 8'h00};
  endfunction

  initial begin
    logic [11:0] s;
    reset = 1'b1; sample_ready = 1'b0; sample_in = '0; ac97_ready = 1'b0; clear_flags = 1'b0;
    for (int i = 0; i < 2; i++)
      cyc(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("reset_data", 32'(to_ac97_data), 32'h0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_running", 32'(running), 32'd0);
    check("reset_underrun", 32'(underrun), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;

    for (int i = 1; i <= 7; i++) cyc(1, 12'(i), 0, 0);
    check("prime7_level", 32'(level), 32'd7);
    check("prime7_running", 32'(running), 32'd0);
    cyc(1, 12'd8, 1, 0);
    check("prime8_level", 32'(level), 32'd8);
    check("prime8_running", 32'(running), 32'd0);
    check("prime8_no_pop", 32'(to_ac97_data), 32'h0);
    cyc(0, 0, 0, 0);
    check("run_rise", 32'(running), 32'd1);

    cyc(0, 0, 1, 0);
    check("pop1_data", 32'(to_ac97_data), 32'h00100);
    check("pop1_level", 32'(level), 32'd7);
    for (int i = 2; i <= 8; i++) begin
      cyc(0, 0, 1, 0);
      check("pop_seq", 32'(to_ac97_data), 32'(slot(12'(i))));
    end
    check("drained_level", 32'(level), 32'd0);

    cyc(0, 0, 1, 0);
    check("underrun_set", 32'(underrun), 32'd1);
    check("underrun_running", 32'(running), 32'd0);
    check("underrun_hold", 32'(to_ac97_data), 32'h00800);
    cyc(0, 0, 0, 1);
    check("underrun_clear", 32'(underrun), 32'd0);

    for (int i = 0; i < 17; i++) cyc(1, 12'(16'h10 + i), 0, 0);
    check("ovf_level", 32'(level), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_running", 32'(running), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0);
      check("ovf_drain", 32'(to_ac97_data), 32'(slot(12'(16'h10 + i))));
    end
    check("ovf_drained", 32'(level), 32'd0);
    cyc(0, 0, 0, 1);
    check("ovf_clear", 32'(overflow), 32'd0);

    for (int i = 0; i < 16; i++) cyc(1, 12'(16'h30 + i), 0, 0);
    check("full_level", 32'(level), 32'd16);
    cyc(1, 12'h040, 1, 0);
    check("fullpop_data", 32'(to_ac97_data), 32'h03000);
    check("fullpop_level", 32'(level), 32'd16);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 0, 1, 0);
      check("fullpop_drain", 32'(to_ac97_data), 32'(slot(12'(16'h30 + i))));
    end
    check("fullpop_empty", 32'(level), 32'd0);

    for (int i = 0; i < 16; i++) cyc(1, 12'(16'h50 + i), 0, 0);
    cyc(1, 12'h060, 0, 1);
    check("prio_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
    check("prio_last", 32'(to_ac97_data), 32'h05F00);
    check("prio_empty", 32'(level), 32'd0);
    cyc(0, 0, 0, 1);
    check("prio_clear", 32'(overflow), 32'd0);

    cyc(1, 12'h800, 0, 0);
    for (int i = 1; i < 40; i++) begin
      s = (i % 2 == 0) ? 12'h800 : 12'h7FF;
      cyc(1, s, 1, 0);
      check("wrap_data", 32'(to_ac97_data), (i % 2 == 1) ? 32'h80000 : 32'h7FF00);
    end
    cyc(0, 0, 1, 0);
    check("wrap_final", 32'(to_ac97_data), 32'h7FF00);
    check("wrap_level", 32'(level), 32'd0);
    check("wrap_underrun", 32'(underrun), 32'd0);
    check("wrap_running", 32'(running), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
